// File: rtl/branch_gshare_predictor.sv
// Global-history branch predictor with selectable index hashing (history only, gshare, concat).
// Lookup is combinational from the fetch PC; training happens on branch resolution.
module branch_gshare_predictor #(
  parameter int PHT_SIZE  = 2048,
  parameter int GHR_BITS  = 11,
  parameter int CNTR_BITS = 2,
  parameter int HASH_MODE = 1,
  parameter int STAT_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          pred_pc,
  output logic                 prediction,
  input  logic                 update_en,
  input  logic [31:0]          update_pc,
  input  logic                 update_val,
  input  logic                 ghr_clear,
  output logic [STAT_BITS-1:0] stat_updates,
  output logic [STAT_BITS-1:0] stat_mispred
);

  localparam int IDX_BITS = $clog2(PHT_SIZE);
  localparam logic [CNTR_BITS-1:0] CNTR_INIT = CNTR_BITS'((1 << (CNTR_BITS - 1)) - 1);
  localparam logic [CNTR_BITS-1:0] CNTR_MAX  = '1;
  localparam logic [STAT_BITS-1:0] STAT_MAX  = '1;

  if (PHT_SIZE < 4 || PHT_SIZE != (1 << IDX_BITS) || IDX_BITS > 30) begin : g_bad_pht_size
    $error("branch_gshare_predictor: PHT_SIZE must be a power of 2 in [4, 2^30]");
  end
  if (GHR_BITS < 1 || GHR_BITS > IDX_BITS) begin : g_bad_ghr_bits
    $error("branch_gshare_predictor: GHR_BITS must be in [1, log2(PHT_SIZE)]");
  end
  if (CNTR_BITS < 1 || CNTR_BITS > 4) begin : g_bad_cntr_bits
    $error("branch_gshare_predictor: CNTR_BITS must be in [1, 4]");
  end
  if (HASH_MODE < 0 || HASH_MODE > 2) begin : g_bad_hash_mode
    $error("branch_gshare_predictor: HASH_MODE must be 0, 1 or 2");
  end
  if (STAT_BITS < 1) begin : g_bad_stat_bits
    $error("branch_gshare_predictor: STAT_BITS must be at least 1");
  end

  logic [CNTR_BITS-1:0] pht [PHT_SIZE];
  logic [GHR_BITS-1:0]  ghr;
  logic [IDX_BITS-1:0]  pred_idx;
  logic [IDX_BITS-1:0]  upd_idx;
  logic [CNTR_BITS-1:0] cnt_cur;
  logic [CNTR_BITS-1:0] cnt_next;
  logic                 mispredict;
  logic                 unused_pc;

  // Mode 2 shifts the PC field above the history; when GHR fills the index the PC part drops out.
  function automatic logic [IDX_BITS-1:0] hash_idx(input logic [IDX_BITS-1:0] p,
                                                   input logic [GHR_BITS-1:0] g);
    logic [IDX_BITS-1:0] h;
    h = IDX_BITS'(g);
    case (HASH_MODE)
      0:       hash_idx = h;
      1:       hash_idx = p ^ h;
      default: hash_idx = (p << GHR_BITS) | h;
    endcase
  endfunction

  assign unused_pc = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0],
                       update_pc[31:IDX_BITS+2], update_pc[1:0]};

  assign pred_idx   = hash_idx(pred_pc[IDX_BITS+1:2], ghr);
  assign upd_idx    = hash_idx(update_pc[IDX_BITS+1:2], ghr);
  assign prediction = pht[pred_idx][CNTR_BITS-1];
  assign cnt_cur    = pht[upd_idx];
  assign mispredict = cnt_cur[CNTR_BITS-1] != update_val;

  always_comb begin
    cnt_next = cnt_cur;
    if (update_val) begin
      if (cnt_cur != CNTR_MAX) cnt_next = cnt_cur + CNTR_BITS'(1);
    end else begin
      if (cnt_cur != '0) cnt_next = cnt_cur - CNTR_BITS'(1);
    end
  end

  // Whole table is reset in a single edge so learned state never survives reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_SIZE; i++) pht[i] <= CNTR_INIT;
    end else if (update_en) begin
      pht[upd_idx] <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || ghr_clear) begin
      ghr <= '0;
    end else if (update_en) begin
      ghr <= GHR_BITS'({ghr, update_val});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_updates <= '0;
      stat_mispred <= '0;
    end else if (update_en) begin
      if (stat_updates != STAT_MAX) stat_updates <= stat_updates + STAT_BITS'(1);
      if (mispredict && stat_mispred != STAT_MAX) stat_mispred <= stat_mispred + STAT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_branch_gshare_predictor.sv
// Testbench for branch_gshare_predictor: four configurations share one stimulus stream,
// vectors carry their own expectations through a scoreboard queue.
module tb_branch_gshare_predictor;

  typedef struct {
    int          sel;
    logic [31:0] pred_pc;
    logic        ue;
    logic [31:0] upc;
    logic        uv;
    logic        clr;
    logic        rst;
    int          exp_pred;
    int          exp_upd;
    int          exp_mis;
    int          exp_ghr;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [31:0] pred_pc;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_val;
  logic        ghr_clear;

  logic        pred_a, pred_b, pred_c, pred_d;
  logic [31:0] upd_a, mis_a, upd_b, mis_b, upd_c, mis_c;
  logic [3:0]  upd_d, mis_d;

  int          sel;
  logic        act_pred;
  logic [31:0] act_upd, act_mis, act_ghr;

  int   n_checks;
  int   n_fail;
  vec_t exp_q[$];
  vec_t table_v[$];

  branch_gshare_predictor #(.PHT_SIZE(2048), .GHR_BITS(1), .CNTR_BITS(2), .HASH_MODE(0), .STAT_BITS(32)) dut_a (
    .clk(clk), .reset(reset), .pred_pc(pred_pc), .prediction(pred_a), .update_en(update_en),
    .update_pc(update_pc), .update_val(update_val), .ghr_clear(ghr_clear),
    .stat_updates(upd_a), .stat_mispred(mis_a));

  branch_gshare_predictor #(.PHT_SIZE(16), .GHR_BITS(4), .CNTR_BITS(2), .HASH_MODE(1), .STAT_BITS(32)) dut_b (
    .clk(clk), .reset(reset), .pred_pc(pred_pc), .prediction(pred_b), .update_en(update_en),
    .update_pc(update_pc), .update_val(update_val), .ghr_clear(ghr_clear),
    .stat_updates(upd_b), .stat_mispred(mis_b));

  branch_gshare_predictor #(.PHT_SIZE(16), .GHR_BITS(2), .CNTR_BITS(2), .HASH_MODE(1), .STAT_BITS(32)) dut_c (
    .clk(clk), .reset(reset), .pred_pc(pred_pc), .prediction(pred_c), .update_en(update_en),
    .update_pc(update_pc), .update_val(update_val), .ghr_clear(ghr_clear),
    .stat_updates(upd_c), .stat_mispred(mis_c));

  branch_gshare_predictor #(.PHT_SIZE(16), .GHR_BITS(2), .CNTR_BITS(2), .HASH_MODE(2), .STAT_BITS(4)) dut_d (
    .clk(clk), .reset(reset), .pred_pc(pred_pc), .prediction(pred_d), .update_en(update_en),
    .update_pc(update_pc), .update_val(update_val), .ghr_clear(ghr_clear),
    .stat_updates(upd_d), .stat_mispred(mis_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the outputs of whichever configuration the current vector targets to one place.
  always_comb begin
    act_pred = 1'b0;
    act_upd  = '0;
    act_mis  = '0;
    act_ghr  = '0;
    case (sel)
      0: begin act_pred = pred_a; act_upd = upd_a; act_mis = mis_a; act_ghr = 32'(dut_a.ghr); end
      1: begin act_pred = pred_b; act_upd = upd_b; act_mis = mis_b; act_ghr = 32'(dut_b.ghr); end
      2: begin act_pred = pred_c; act_upd = upd_c; act_mis = mis_c; act_ghr = 32'(dut_c.ghr); end
      default: begin act_pred = pred_d; act_upd = 32'(upd_d); act_mis = 32'(mis_d); act_ghr = 32'(dut_d.ghr); end
    endcase
  end

  function automatic vec_t mk(input int s, input logic [31:0] ppc, input logic ue,
                              input logic [31:0] upc, input logic uv, input logic clr,
                              input logic rst, input int ep, input int eu, input int em,
                              input int eg);
    vec_t v;
    v.sel = s; v.pred_pc = ppc; v.ue = ue; v.upc = upc; v.uv = uv; v.clr = clr; v.rst = rst;
    v.exp_pred = ep; v.exp_upd = eu; v.exp_mis = em; v.exp_ghr = eg;
    return v;
  endfunction

  task automatic compare(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s (sel %0d) at %0t: got %0d, expected %0d", name, sel, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    sel        = v.sel;
    reset      = v.rst;
    pred_pc    = v.pred_pc;
    update_en  = v.ue;
    update_pc  = v.upc;
    update_val = v.uv;
    ghr_clear  = v.clr;
    exp_q.push_back(v);
  endtask

  // Prediction is checked before the edge (read-before-write), stats and history after it.
  task automatic checkOutput();
    vec_t v;
    if (exp_q.size() == 0) begin
      compare("scoreboard_empty", 1, 0);
      return;
    end
    v = exp_q.pop_front();
    #1;
    if (v.exp_pred >= 0) compare("prediction", int'(act_pred), v.exp_pred);
    @(posedge clk);
    #1;
    compare("stat_updates", int'(act_upd), v.exp_upd);
    compare("stat_mispred", int'(act_mis), v.exp_mis);
    if (v.exp_ghr >= 0) compare("ghr", int'(act_ghr), v.exp_ghr);
  endtask

  task automatic run(input vec_t v);
    applyStimulus(v);
    checkOutput();
  endtask

  task automatic reset_all(input int s);
    run(mk(s, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, -1, 0, 0, 0));
    run(mk(s, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, -1, 0, 0, 0));
  endtask

  task automatic line_trace();
    $display("[TB] trace ghr=%h upd_idx=%0d cnt %0d->%0d pred=%b",
             dut_b.ghr, dut_b.upd_idx, dut_b.cnt_cur, dut_b.cnt_next, dut_b.prediction);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    sel        = 0;
    reset      = 1'b1;
    pred_pc    = '0;
    update_en  = 1'b0;
    update_pc  = '0;
    update_val = 1'b0;
    ghr_clear  = 1'b0;

    // Cold reset, cold lookups on every configuration, then counter saturation on dut_a.
    table_v.push_back(mk(0, 32'h0, 0, 32'h0, 0, 0, 1, -1, 0, 0, 0));
    table_v.push_back(mk(0, 32'h0, 0, 32'h0, 0, 0, 1, -1, 0, 0, 0));
    for (int s = 0; s < 4; s++)
      table_v.push_back(mk(s, 32'h200, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0));
    table_v.push_back(mk(0, 32'h100, 1, 32'h100, 1, 0, 0, 0, 1, 1, 1));
    table_v.push_back(mk(0, 32'h100, 1, 32'h100, 1, 0, 0, 0, 2, 2, 1));
    table_v.push_back(mk(0, 32'h100, 1, 32'h100, 1, 0, 0, 1, 3, 2, 1));
    table_v.push_back(mk(0, 32'h100, 1, 32'h100, 1, 0, 0, 1, 4, 2, 1));
    table_v.push_back(mk(0, 32'h100, 1, 32'h100, 1, 0, 0, 1, 5, 2, 1));
    table_v.push_back(mk(0, 32'h100, 1, 32'h100, 0, 0, 0, 1, 6, 3, 0));
    table_v.push_back(mk(0, 32'h100, 0, 32'h0,   0, 0, 0, 1, 6, 3, 0));
    for (int i = 0; i < table_v.size(); i++) run(table_v[i]);

    // Gshare aliasing split: same history, two PCs landing on indices 0xB and 0x4.
    reset_all(1);
    run(mk(1, 32'h10, 1, 32'h10, 1, 0, 0, 0, 1, 1, 1));
    run(mk(1, 32'h10, 1, 32'h10, 1, 0, 0, 0, 2, 2, 3));
    run(mk(1, 32'h10, 1, 32'h10, 1, 0, 0, 0, 3, 3, 7));
    run(mk(1, 32'h10, 1, 32'h10, 1, 0, 0, 0, 4, 4, 15));
    run(mk(1, 32'h10, 1, 32'h10, 1, 0, 0, 0, 5, 5, 15));
    run(mk(1, 32'h10, 1, 32'h10, 1, 0, 0, 1, 6, 5, 15));
    line_trace();
    run(mk(1, 32'h10, 0, 32'h0, 0, 0, 0, 1, 6, 5, 15));
    run(mk(1, 32'h2C, 0, 32'h0, 0, 0, 0, 1, 6, 5, 15));
    compare("pht_b_idx_0xB", int'(dut_b.pht[11]), 3);
    compare("pht_b_idx_0x4", int'(dut_b.pht[4]), 2);

    // Same-cycle lookup and update on index 4: old counter this cycle, new one next cycle.
    reset_all(1);
    run(mk(1, 32'h10, 1, 32'h10, 1, 0, 0, 0, 1, 1, 1));
    run(mk(1, 32'h14, 0, 32'h0,  0, 0, 0, 1, 1, 1, 1));

    // Build GHR=0x5, then update and clear together; finally decrement saturation at 0.
    reset_all(1);
    run(mk(1, 32'h0, 1, 32'h0, 0, 0, 0, 0, 1, 0, 0));
    run(mk(1, 32'h0, 1, 32'h0, 1, 0, 0, 0, 2, 1, 1));
    run(mk(1, 32'h0, 1, 32'h0, 0, 0, 0, 0, 3, 1, 2));
    run(mk(1, 32'h0, 1, 32'h0, 1, 0, 0, 0, 4, 2, 5));
    line_trace();
    run(mk(1, 32'h0, 1, 32'h0, 1, 1, 0, 0, 5, 3, 0));
    run(mk(1, 32'h14, 0, 32'h0, 0, 0, 0, 1, 5, 3, 0));
    run(mk(1, 32'h4, 1, 32'h4, 0, 0, 0, 0, 6, 3, 0));
    run(mk(1, 32'h4, 0, 32'h0, 0, 0, 0, 0, 6, 3, 0));
    run(mk(1, 32'h0, 0, 32'h0, 0, 1, 0, 0, 6, 3, 0));

    // Alternating T,N on one PC: only the first three updates can mispredict (two of them do).
    reset_all(2);
    for (int k = 0; k < 80; k++) begin
      logic v_t;
      v_t = (k % 2 == 0);
      run(mk(2, 32'h0, 1, 32'h0, v_t, 0, 0, (k < 4) ? 0 : int'(v_t), k + 1,
             (k < 2) ? 1 : 2, v_t ? 1 : 2));
    end

    // 4-bit statistics saturate at 15; concat index places PC bits above the history.
    reset_all(3);
    for (int k = 0; k < 20; k++)
      run(mk(3, 32'h8, 1, 32'h8, 1, 0, 0, (k < 3) ? 0 : 1, (k < 15) ? k + 1 : 15,
             (k < 3) ? k + 1 : 3, (k == 0) ? 1 : 3));
    run(mk(3, 32'h0, 0, 32'h0, 0, 0, 0, 0, 15, 3, 3));
    run(mk(3, 32'h8, 0, 32'h0, 0, 0, 0, 1, 15, 3, 3));

    // Reset wins over a concurrent update and wipes learned state in one edge.
    run(mk(3, 32'h8, 1, 32'h8, 1, 1, 1, -1, 0, 0, 0));
    run(mk(3, 32'h8, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
